bcd_score_accum: RTL and testbench

BCD_SCORE_ACCUM -- requirements
Module: bcd_score_accum

---
 rtl/bcd_score_accum.sv | 119 +++++++++++
 tb/tb_bcd_score_accum.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_score_accum.sv
// Packed-BCD score accumulator: adds one digit per cycle and commits the result atomically.
// Optional build macro BCD_SAT_EN: a carry out of the top digit saturates the score to all 9s.
module bcd_score_accum #(
    parameter int DIGITS = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   addend,
    input  logic                  clear,
    output logic                  ready,
    output logic [4*DIGITS-1:0]   score,
    output logic                  done,
    output logic                  overflow,
    output logic [1:0]            state_dbg
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state, state_next;
    logic [DIGITS-1:0][3:0]    work;
    logic [DIGITS-1:0][3:0]    add_q;
    logic [IW-1:0]             idx;
    logic                      carry;
    logic [4:0]                dig_t;
    logic [3:0]                dig_sum;
    logic                      dig_carry;
    logic                      last_digit;

    function automatic logic [DIGITS-1:0][3:0] clamp_bcd(input logic [DIGITS-1:0][3:0] v);
        logic [DIGITS-1:0][3:0] r;
        for (int i = 0; i < DIGITS; i++) begin
            r[i] = (v[i] > 4'd9) ? 4'd9 : v[i];
        end
        return r;
    endfunction

    // Handshake: a request is taken on the rising edge where start & ready are both high;
    // ready is only offered in IDLE and is withheld while clear has priority.
    assign ready      = (state == IDLE) & ~clear;
    assign state_dbg  = state;
    assign last_digit = (idx == IW'(DIGITS - 1));

    always_comb begin
        dig_t     = 5'(work[idx]) + 5'(add_q[idx]) + 5'(carry);
        dig_sum   = dig_t[3:0];
        dig_carry = 1'b0;
        if (dig_t > 5'd9) begin
            dig_sum   = dig_t[3:0] + 4'd6;
            dig_carry = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && ready) state_next = ADD;
            ADD:     if (last_digit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            score    <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
            work     <= '0;
            add_q    <= '0;
            idx      <= '0;
            carry    <= 1'b0;
        end else begin
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (clear) begin
                        score    <= '0;
                        overflow <= 1'b0;
                    end else if (start) begin
                        add_q <= clamp_bcd(addend);
                        work  <= score;
                        idx   <= '0;
                        carry <= 1'b0;
                    end
                end
                ADD: begin
                    work[idx] <= dig_sum;
                    carry     <= dig_carry;
                    if (!last_digit) idx <= idx + 1'b1;
                end
                DONE: begin
`ifdef BCD_SAT_EN
                    score <= carry ? {DIGITS{4'h9}} : work;
`else
                    score <= work;
`endif
                    if (carry) overflow <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_score_accum.sv
// Bench for bcd_score_accum: decimal reference model, directed corner cases and random traffic.
// Honours BCD_SAT_EN in the model when the same macro is defined for the build.
module tb_bcd_score_accum;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         start;
    logic         clear;
    logic [W-1:0] addend;
    logic         ready;
    logic [W-1:0] score;
    logic         done;
    logic         overflow;
    logic [1:0]   state_dbg;

    bcd_score_accum #(.DIGITS(DIGITS)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .start     (start),
        .addend    (addend),
        .clear     (clear),
        .ready     (ready),
        .score     (score),
        .done      (done),
        .overflow  (overflow),
        .state_dbg (state_dbg)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: decimal arithmetic on whole numbers plus a busy countdown.
    logic [W-1:0] m_score;
    bit           m_ovf;
    bit           m_done;
    bit           m_pend_ovf;
    int           busy;
    logic [W-1:0] exp_q[$];

    logic [W-1:0] s_score;
    logic         s_done, s_ovf, s_ready;

    function automatic longint lim10();
        longint r = 1;
        for (int i = 0; i < DIGITS; i++) r = r * 10;
        return r;
    endfunction

    function automatic longint to_int(input logic [W-1:0] v);
        longint r = 0;
        int     d;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = int'(v[i*4 +: 4]);
            if (d > 9) d = 9;
            r = r * 10 + d;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input longint x);
        logic [W-1:0] v = '0;
        for (int i = 0; i < DIGITS; i++) begin
            v[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_score    = '0;
        m_ovf      = 1'b0;
        m_done     = 1'b0;
        m_pend_ovf = 1'b0;
        busy       = 0;
        exp_q.delete();
    endtask

    task automatic model_edge(input bit s, input bit c, input logic [W-1:0] a);
        longint sum;
        m_done = 1'b0;
        if (busy > 0) begin
            busy--;
            if (busy == 0) begin
                m_score = exp_q.pop_front();
                if (m_pend_ovf) m_ovf = 1'b1;
                m_done = 1'b1;
            end
        end else if (c) begin
            m_score = '0;
            m_ovf   = 1'b0;
        end else if (s) begin
            sum        = to_int(m_score) + to_int(a);
            m_pend_ovf = (sum >= lim10());
`ifdef BCD_SAT_EN
            if (m_pend_ovf) sum = lim10() - 1;
`else
            if (m_pend_ovf) sum = sum - lim10();
`endif
            exp_q.push_back(to_bcd(sum));
            busy = DIGITS + 1;
        end
    endtask

    // One clock cycle: drive, compare every output against the model, then advance the model.
    task automatic step(input bit s, input bit c, input logic [W-1:0] a);
        @(negedge Clk);
        start  = s;
        clear  = c;
        addend = a;
        #1;
        s_score = score;
        s_done  = done;
        s_ovf   = overflow;
        s_ready = ready;
        chk("score", 64'(score), 64'(m_score));
        chk("done", 64'(done), 64'(m_done));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("ready", 64'(ready), 64'((busy == 0) && !c));
        @(posedge Clk);
        model_edge(s, c, a);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        #2;
        Reset = 1'b1;
        start = 1'b0;
        clear = 1'b0;
        #1;
        chk("rst_score", 64'(score), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        chk("rst_ready", 64'(ready), 64'(1));
        model_reset();
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    // Done is observed in the sampling window after edge DIGITS+1, i.e. DIGITS+2 steps on.
    task automatic add_and_wait(input logic [W-1:0] a);
        int lat  = 0;
        bit seen = 0;
        step(1'b1, 1'b0, a);
        for (int k = 0; k < 20 && !seen; k++) begin
            step(1'b0, 1'b0, '0);
            lat++;
            if (s_done) seen = 1;
        end
        chk("latency", 64'(seen ? lat : -1), 64'(DIGITS + 2));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done;
        int last_t, t;
        Reset  = 1'b1;
        start  = 1'b0;
        clear  = 1'b0;
        addend = '0;
        model_reset();
        #12;
        chk("init_score", 64'(score), 64'(0));
        chk("init_overflow", 64'(overflow), 64'(0));
        chk("init_done", 64'(done), 64'(0));
        @(negedge Clk);
        Reset = 1'b0;

        // Carry ripples through three digits.
        step(1'b0, 1'b1, '0);
        add_and_wait(16'h0999);
        add_and_wait(16'h0001);
        chk("ripple_score", 64'(s_score), 64'(16'h1000));
        chk("ripple_ovf", 64'(s_ovf), 64'(0));
        step(1'b0, 1'b0, '0);
        chk("done_one_cycle", 64'(s_done), 64'(0));

        // Carry out of the top digit; overflow stays sticky across a later add.
        step(1'b0, 1'b1, '0);
        add_and_wait(16'h9999);
        add_and_wait(16'h0001);
`ifdef BCD_SAT_EN
        chk("top_carry_score", 64'(s_score), 64'(16'h9999));
`else
        chk("top_carry_score", 64'(s_score), 64'(16'h0000));
`endif
        chk("top_carry_ovf", 64'(s_ovf), 64'(1));
        add_and_wait(16'h0000);
        chk("sticky_ovf", 64'(s_ovf), 64'(1));

        // clear wins over start in the same IDLE cycle.
        step(1'b0, 1'b1, '0);
        add_and_wait(16'h1234);
        chk("pre_clear_score", 64'(s_score), 64'(16'h1234));
        step(1'b1, 1'b1, 16'h0001);
        chk("clear_ready", 64'(s_ready), 64'(0));
        n_done = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, '0);
            if (s_done) n_done++;
        end
        chk("clear_no_done", 64'(n_done), 64'(0));
        chk("clear_score", 64'(s_score), 64'(16'h0000));

        // Reset during the cycle that processes digit index 2.
        add_and_wait(16'h0500);
        step(1'b1, 1'b0, 16'h0500);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        do_reset();
        step(1'b0, 1'b0, '0);
        chk("post_rst_ready", 64'(s_ready), 64'(1));
        chk("post_rst_score", 64'(s_score), 64'(16'h0000));
        n_done = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, '0);
            if (s_done) n_done++;
        end
        chk("post_rst_no_done", 64'(n_done), 64'(0));

        // Illegal addend digit is clamped to 9.
        add_and_wait(16'h00A5);
        chk("clamp_score", 64'(s_score), 64'(16'h0095));

        // start held high: back-to-back increments at a fixed period.
        step(1'b0, 1'b1, '0);
        n_done = 0;
        last_t = -1;
        t      = 0;
        for (int k = 0; k < 40 && n_done < 3; k++) begin
            step(1'b1, 1'b0, 16'h0001);
            t++;
            if (s_done) begin
                if (last_t >= 0) chk("held_period", 64'(t - last_t), 64'(DIGITS + 2));
                last_t = t;
                n_done++;
            end
        end
        chk("held_count", 64'(n_done), 64'(3));
        chk("held_score", 64'(s_score), 64'(16'h0003));
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, '0);

        // Random traffic, including illegal digits and occasional resets.
        for (int k = 0; k < 600; k++) begin
            logic [W-1:0] a;
            for (int d = 0; d < DIGITS; d++) a[d*4 +: 4] = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) do_reset();
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0), a);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
